// File: rtl/fifo_pkg.sv
// Shared helpers for the FWFT FIFO slice: constant-width functions used at elaboration.
package fifo_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned rem;
    result = 0;
    rem    = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  // Level counters need one extra bit so that a completely full FIFO is representable.
  function automatic int unsigned level_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// Pointer, occupancy and flag bookkeeping for sync_fifo_fwft; drives RAM write/read enables.
module sync_fifo_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
  parameter int unsigned AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  re,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  head_valid,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned LW    = level_width(ADDR_WIDTH);
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  localparam logic [LW-1:0] LvlFull = LW'(DEPTH);
  localparam logic [LW-1:0] LvlAf   = LW'(AF_LEVEL);
  localparam logic [LW-1:0] LvlAe   = LW'(AE_LEVEL);

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]         ram_cnt_q, ram_cnt_d, level_q, level_d;
  logic                  head_valid_q, head_valid_d;
  logic                  full_q, full_d, af_q, af_d, ae_q, ae_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  push, pop, refill;

  always_comb begin
    push   = wr_en && !full_q;
    pop    = rd_en && head_valid_q;
    // The head register is reloaded whenever it is empty or being consumed.
    refill = (ram_cnt_q != '0) && (!head_valid_q || pop);

    wptr_d       = push ? wptr_q + ADDR_WIDTH'(1) : wptr_q;
    rptr_d       = refill ? rptr_q + ADDR_WIDTH'(1) : rptr_q;
    ram_cnt_d    = ram_cnt_q + LW'(push) - LW'(refill);
    head_valid_d = refill || (head_valid_q && !pop);
    level_d      = level_q + LW'(push) - LW'(pop);
    ovf_d        = wr_en && full_q;
    unf_d        = rd_en && !head_valid_q;

    if (flush) begin
      wptr_d       = '0;
      rptr_d       = '0;
      ram_cnt_d    = '0;
      head_valid_d = 1'b0;
      level_d      = '0;
      ovf_d        = 1'b0;
      unf_d        = 1'b0;
    end

    full_d = (level_d == LvlFull);
    af_d   = (level_d >= LvlAf);
    ae_d   = (level_d <= LvlAe);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      ram_cnt_q    <= '0;
      level_q      <= '0;
      head_valid_q <= 1'b0;
      full_q       <= 1'b0;
      af_q         <= (AF_LEVEL == 0);
      ae_q         <= 1'b1;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      ram_cnt_q    <= ram_cnt_d;
      level_q      <= level_d;
      head_valid_q <= head_valid_d;
      full_q       <= full_d;
      af_q         <= af_d;
      ae_q         <= ae_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  assign we           = push && !flush;
  assign re           = refill && !flush;
  assign waddr        = wptr_q;
  assign raddr        = rptr_q;
  assign head_valid   = head_valid_q;
  assign full         = full_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO: RAM array plus registered head word.
module sync_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
  parameter int unsigned AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
    $error("sync_fifo_fwft: AF_LEVEL must lie in 1..DEPTH");
  end
  if (AE_LEVEL > DEPTH - 1) begin : g_bad_ae_level
    $error("sync_fifo_fwft: AE_LEVEL must lie in 0..DEPTH-1");
  end
  if (clog2(DEPTH) != ADDR_WIDTH) begin : g_bad_depth
    $error("sync_fifo_fwft: DEPTH does not match ADDR_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] head_q;
  logic [ADDR_WIDTH-1:0] waddr, raddr;
  logic                  we, re, head_valid;

  sync_fifo_ptr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .AF_LEVEL   (AF_LEVEL),
    .AE_LEVEL   (AE_LEVEL)
  ) u_ptr (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .we           (we),
    .waddr        (waddr),
    .re           (re),
    .raddr        (raddr),
    .head_valid   (head_valid),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wr_data;
    end
  end

  // Registered RAM read port doubles as the head-of-queue register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
    end else if (flush) begin
      head_q <= '0;
    end else if (re) begin
      head_q <= mem[raddr];
    end
  end

  assign rd_data = head_q;
  assign empty   = !head_valid;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Self-checking bench for sync_fifo_fwft: directed vector table, corner sequences, random vs queue model.
module tb_sync_fifo_fwft;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AFL   = 2;
  localparam int unsigned AEL   = 1;

  logic          clk = 1'b0;
  logic          rst, flush, wr_en, rd_en;
  logic [DW-1:0] wr_data, rd_data;
  logic          full, almost_full, empty, almost_empty, overflow, underflow;
  logic [AW:0]   level;

  int n_tests = 0;
  int n_fail  = 0;

  sync_fifo_fwft #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AF_LEVEL   (AFL),
    .AE_LEVEL   (AEL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .almost_full  (almost_full),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".empty"},        32'(empty),        32'd1);
    chk({tag, ".full"},         32'(full),         32'd0);
    chk({tag, ".almost_full"},  32'(almost_full),  32'd0);
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'd1);
    chk({tag, ".level"},        32'(level),        32'd0);
    chk({tag, ".overflow"},     32'(overflow),     32'd0);
    chk({tag, ".underflow"},    32'(underflow),    32'd0);
    chk({tag, ".rd_data"},      32'(rd_data),      32'd0);
  endtask

  // Reference model: ordered contents plus whether the oldest word is already presented.
  logic [DW-1:0] q[$];
  bit            m_hv, m_ov, m_un;

  task automatic model_step(input bit fl, input bit wr, input logic [DW-1:0] wd, input bit rd);
    int held;
    bit push, pop, refill;
    held = q.size();
    if (fl) begin
      q.delete();
      m_hv = 0;
      m_ov = 0;
      m_un = 0;
      return;
    end
    push   = wr && (held < DEPTH);
    pop    = rd && m_hv;
    m_ov   = wr && (held == DEPTH);
    m_un   = rd && !m_hv;
    // A word not yet presented moves to the head when the head slot is free or being consumed.
    refill = ((held - int'(m_hv)) > 0) && (!m_hv || pop);
    if (pop) void'(q.pop_front());
    if (push) q.push_back(wd);
    m_hv = refill || (m_hv && !pop);
  endtask

  task automatic check_model(input string tag);
    int held;
    held = q.size();
    chk({tag, ".empty"},        32'(empty),        32'(!m_hv));
    chk({tag, ".level"},        32'(level),        32'(held));
    chk({tag, ".full"},         32'(full),         32'(held == DEPTH));
    chk({tag, ".almost_full"},  32'(almost_full),  32'(held >= AFL));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(held <= AEL));
    chk({tag, ".overflow"},     32'(overflow),     32'(m_ov));
    chk({tag, ".underflow"},    32'(underflow),    32'(m_un));
    if (m_hv) chk({tag, ".rd_data"}, 32'(rd_data), 32'(q[0]));
  endtask

  task automatic cycle(input string tag, input bit fl, input bit wr, input logic [DW-1:0] wd,
                       input bit rd);
    flush   = fl;
    wr_en   = wr;
    wr_data = wd;
    rd_en   = rd;
    model_step(fl, wr, wd, rd);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    flush = 0;
    wr_en = 0;
    rd_en = 0;
    rst   = 1;
    @(posedge clk);
    #1;
    rst = 0;
    q.delete();
    m_hv = 0;
    m_ov = 0;
    m_un = 0;
  endtask

  typedef struct {
    bit            fl, wr;
    logic [DW-1:0] wd;
    bit            rd;
    bit            e, f, af, ae;
    int            lvl;
    bit            ov, un;
    logic [DW-1:0] d;
  } vec_t;

  vec_t vecs[13];

  initial begin
    //          fl wr wd     rd  e  f af ae lvl ov un  d
    vecs[0]  = '{0, 1, 8'h11, 0, 1, 0, 0, 1, 1, 0, 0, 8'h00};
    vecs[1]  = '{0, 1, 8'h22, 0, 0, 0, 1, 0, 2, 0, 0, 8'h11};
    vecs[2]  = '{0, 1, 8'h33, 0, 0, 0, 1, 0, 3, 0, 0, 8'h11};
    vecs[3]  = '{0, 1, 8'h44, 0, 0, 1, 1, 0, 4, 0, 0, 8'h11};
    vecs[4]  = '{0, 1, 8'h55, 0, 0, 1, 1, 0, 4, 1, 0, 8'h11};
    vecs[5]  = '{0, 0, 8'h00, 0, 0, 1, 1, 0, 4, 0, 0, 8'h11};
    vecs[6]  = '{0, 0, 8'h00, 1, 0, 0, 1, 0, 3, 0, 0, 8'h22};
    vecs[7]  = '{0, 0, 8'h00, 1, 0, 0, 1, 0, 2, 0, 0, 8'h33};
    vecs[8]  = '{0, 0, 8'h00, 1, 0, 0, 0, 1, 1, 0, 0, 8'h44};
    vecs[9]  = '{0, 0, 8'h00, 1, 1, 0, 0, 1, 0, 0, 0, 8'h00};
    vecs[10] = '{0, 0, 8'h00, 1, 1, 0, 0, 1, 0, 0, 1, 8'h00};
    vecs[11] = '{0, 1, 8'hA0, 1, 1, 0, 0, 1, 1, 0, 1, 8'h00};
    vecs[12] = '{0, 0, 8'h00, 0, 0, 0, 0, 1, 1, 0, 0, 8'hA0};

    flush   = 0;
    wr_en   = 0;
    rd_en   = 0;
    wr_data = '0;
    rst     = 1;
    #2;
    chk_reset_vals("rst_async");
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst_held");
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("idle");

    for (int i = 0; i < 13; i++) begin
      string t;
      t       = $sformatf("vec%0d", i);
      flush   = vecs[i].fl;
      wr_en   = vecs[i].wr;
      wr_data = vecs[i].wd;
      rd_en   = vecs[i].rd;
      @(posedge clk);
      #1;
      chk({t, ".empty"},        32'(empty),        32'(vecs[i].e));
      chk({t, ".full"},         32'(full),         32'(vecs[i].f));
      chk({t, ".almost_full"},  32'(almost_full),  32'(vecs[i].af));
      chk({t, ".almost_empty"}, 32'(almost_empty), 32'(vecs[i].ae));
      chk({t, ".level"},        32'(level),        32'(vecs[i].lvl));
      chk({t, ".overflow"},     32'(overflow),     32'(vecs[i].ov));
      chk({t, ".underflow"},    32'(underflow),    32'(vecs[i].un));
      if (!vecs[i].e) chk({t, ".rd_data"}, 32'(rd_data), 32'(vecs[i].d));
    end

    // Sustained push+pop at level 2 wraps the pointers several times.
    do_reset();
    cycle("fill_a", 0, 1, 8'hC1, 0);
    cycle("fill_b", 0, 1, 8'hC2, 0);
    for (int i = 0; i < 10; i++) begin
      cycle($sformatf("stream%0d", i), 0, 1, 8'(8'h30 + i), 1);
      chk($sformatf("stream%0d.level2", i), 32'(level), 32'd2);
    end

    // Flush wins over a simultaneous push at level 3.
    cycle("pre_flush", 0, 1, 8'hD3, 0);
    chk("pre_flush.level3", 32'(level), 32'd3);
    cycle("flush_push", 1, 1, 8'hEE, 0);
    chk("flush_push.level", 32'(level), 32'd0);
    chk("flush_push.empty", 32'(empty), 32'd1);
    chk("flush_push.overflow", 32'(overflow), 32'd0);
    cycle("post_flush", 0, 0, 8'h00, 0);
    chk_reset_vals("post_flush");

    // Asynchronous reset in the middle of a stream.
    cycle("mid_a", 0, 1, 8'h71, 0);
    cycle("mid_b", 0, 1, 8'h72, 0);
    cycle("mid_c", 0, 1, 8'h73, 1);
    rst = 1;
    #2;
    chk_reset_vals("rst_mid");
    wr_en = 0;
    rd_en = 0;
    @(posedge clk);
    #1;
    rst = 0;
    q.delete();
    m_hv = 0;
    m_ov = 0;
    m_un = 0;

    // Random traffic with phases biased towards filling and towards draining.
    for (int i = 0; i < 3000; i++) begin
      int unsigned wbias, rbias;
      bit fl, wr, rd;
      wbias = ((i / 200) % 2 == 0) ? 75 : 35;
      rbias = ((i / 200) % 2 == 0) ? 35 : 75;
      fl    = ($urandom_range(0, 63) == 0);
      wr    = ($urandom_range(0, 99) < wbias);
      rd    = ($urandom_range(0, 99) < rbias);
      cycle($sformatf("rnd%0d", i), fl, wr, 8'($urandom), rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
